// File: rtl/rom_based_sign_magnitude_subtractor_if.sv
// Operand/result handshake bundle for the sign-magnitude subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface rom_based_sign_magnitude_subtractor_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   diff;
  logic [15:0]           op_count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, op_count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, op_count
  );
endinterface

// File: rtl/rom_based_sign_magnitude_subtractor.sv
// Two-stage sign-magnitude subtractor (a - b). Magnitudes come from SUM/DIFF
// tables built at elaboration; sign is resolved in stage 1, -0 folded to +0.
module rom_based_sign_magnitude_subtractor #(
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  rom_based_sign_magnitude_subtractor_if.slave bus
);

  localparam int MW    = DATA_WIDTH - 1;
  localparam int AW    = 2 * MW;
  localparam int DEPTH = 1 << AW;

  logic [DATA_WIDTH-1:0] sum_rom  [DEPTH];
  logic [DATA_WIDTH-1:0] diff_rom [DEPTH];

  // Table address is {ma, mb}: upper half is the minuend magnitude.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int MA = i >> MW;
    localparam int MB = i % (1 << MW);
    assign sum_rom[i]  = DATA_WIDTH'(MA + MB);
    assign diff_rom[i] = DATA_WIDTH'((MA > MB) ? (MA - MB) : (MB - MA));
  end

  logic                  s1_valid_q, s1_valid_d;
  logic [AW-1:0]         s1_addr_q,  s1_addr_d;
  logic                  s1_same_q,  s1_same_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH:0]   diff_q,     diff_d;
  logic [15:0]           op_count_q, op_count_d;

  logic [MW-1:0]         ma, mb;
  logic                  sa, sbn, in_same, in_sign;
  logic [DATA_WIDTH-1:0] mag;
  logic                  s2_hold, s1_adv, in_ready, accept, consume;

  always_comb begin
    ma      = bus.a[MW-1:0];
    mb      = bus.b[MW-1:0];
    sa      = bus.a[DATA_WIDTH-1];
    sbn     = ~bus.b[DATA_WIDTH-1];
    in_same = (sa == sbn);
    if (in_same)      in_sign = sa;
    else if (ma > mb) in_sign = sa;
    else if (ma < mb) in_sign = sbn;
    else              in_sign = 1'b0;
  end

  always_comb begin
    consume  = s2_valid_q && bus.out_ready;
    s2_hold  = s2_valid_q && !bus.out_ready;
    s1_adv   = s1_valid_q && !s2_hold;
    in_ready = !(s1_valid_q && s2_hold);
    accept   = bus.in_valid && in_ready;
    mag      = s1_same_q ? sum_rom[s1_addr_q] : diff_rom[s1_addr_q];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_same_d  = s1_same_q;
    s1_sign_d  = s1_sign_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    op_count_d = op_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = {ma, mb};
      s1_same_d  = in_same;
      s1_sign_d  = in_sign;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 either holds under backpressure or takes whatever stage 1 has.
    if (!s2_hold) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = {((mag == '0) ? 1'b0 : s1_sign_q), mag};
      end
    end

    if (consume) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_same_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_same_q  <= s1_same_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.diff      = diff_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_rom_based_sign_magnitude_subtractor.sv
// Directed bench for the sign-magnitude subtractor: hand-computed vectors,
// backpressure, mid-stream reset and a full sweep against an integer model.
module tb_rom_based_sign_magnitude_subtractor;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  rom_based_sign_magnitude_subtractor_if #(.DATA_WIDTH(4)) bus ();

  rom_based_sign_magnitude_subtractor #(.DATA_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: a - b, result in sign-magnitude with +0 for zero.
  function automatic logic [4:0] ref_sub(input logic [3:0] av, input logic [3:0] bv);
    int va, vb, r;
    va = av[3] ? -int'(av[2:0]) : int'(av[2:0]);
    vb = bv[3] ? -int'(bv[2:0]) : int'(bv[2:0]);
    r  = va - vb;
    if (r < 0) return {1'b1, 4'(-r)};
    return {1'b0, 4'(r)};
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic [4:0] exp);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.diff), 32'(exp));
    step();
  endtask

  logic [3:0] bp_a   [4];
  logic [3:0] bp_b   [4];
  logic [4:0] bp_exp [4];
  logic [4:0] exp_q  [$];
  logic [4:0] d0;
  int idx, got, stale, cyc;

  initial begin
    bus.a = '0;
    bus.b = '0;
    do_reset();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff",      32'(bus.diff),      32'd0);
    check("rst_op_count",  32'(bus.op_count),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // +3 - +5 = -2, two-cycle latency
    bus.a = 4'b0011; bus.b = 4'b0101; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("p3_m5", 32'(bus.diff), 32'b10010);
    step();
    check("op_count_1", 32'(bus.op_count), 32'd1);
    check("drained", 32'(bus.out_valid), 32'd0);

    // back-to-back: -7 - +7 = -14, +4 - -6 = +10
    bus.a = 4'b1111; bus.b = 4'b0111; bus.in_valid = 1'b1;
    step();
    bus.a = 4'b0100; bus.b = 4'b1110;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("m7_p7", 32'(bus.diff), 32'b11110);
    step();
    check("p4_m6_valid", 32'(bus.out_valid), 32'd1);
    check("p4_m6", 32'(bus.diff), 32'b01010);
    step();
    check("op_count_3", 32'(bus.op_count), 32'd3);

    run_one("neg0_minus_pos0", 4'b1000, 4'b0000, 5'b00000);
    run_one("p5_minus_p5",     4'b0101, 4'b0101, 5'b00000);
    run_one("m2_minus_m2",     4'b1010, 4'b1010, 5'b00000);
    run_one("p0_minus_m7",     4'b0000, 4'b1111, 5'b00111);
    check("op_count_7", 32'(bus.op_count), 32'd7);

    // Backpressure: four pairs against a stalled consumer
    do_reset();
    bp_a[0] = 4'b0001; bp_b[0] = 4'b0010; bp_exp[0] = 5'b10001;
    bp_a[1] = 4'b0110; bp_b[1] = 4'b1001; bp_exp[1] = 5'b00111;
    bp_a[2] = 4'b1011; bp_b[2] = 4'b0100; bp_exp[2] = 5'b10111;
    bp_a[3] = 4'b1101; bp_b[3] = 4'b1111; bp_exp[3] = 5'b00010;
    bus.out_ready = 1'b0;
    bus.a = bp_a[0]; bus.b = bp_b[0]; bus.in_valid = 1'b1;
    step();
    bus.a = bp_a[1]; bus.b = bp_b[1];
    check("bp_ready_1", 32'(bus.in_ready), 32'd1);
    step();
    bus.a = bp_a[2]; bus.b = bp_b[2];
    check("bp_ready_0", 32'(bus.in_ready), 32'd0);
    check("bp_valid",   32'(bus.out_valid), 32'd1);
    check("bp_diff0",   32'(bus.diff), 32'(bp_exp[0]));
    step();
    step();
    check("bp_stable_diff",  32'(bus.diff), 32'(bp_exp[0]));
    check("bp_stable_ready", 32'(bus.in_ready), 32'd0);
    check("bp_stable_cnt",   32'(bus.op_count), 32'd0);

    bus.out_ready = 1'b1;
    idx = 2;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      if (bus.out_valid) begin
        check("bp_order", 32'(bus.diff), 32'(bp_exp[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        if (idx < 4) begin
          bus.a = bp_a[idx];
          bus.b = bp_b[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      step();
      cyc++;
    end
    check("bp_got_4",   32'(got), 32'd4);
    check("bp_count_4", 32'(bus.op_count), 32'd4);
    check("bp_no_dup",  32'(bus.out_valid), 32'd0);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    bus.a = 4'b0111; bus.b = 4'b1111; bus.in_valid = 1'b1;
    step();
    bus.a = 4'b0001; bus.b = 4'b0001;
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_full", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_diff",  32'(bus.diff),      32'd0);
    check("mid_rst_count", 32'(bus.op_count),  32'd0);
    bus.out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) stale++;
      step();
    end
    check("no_stale", 32'(stale), 32'd0);
    check("no_stale_count", 32'(bus.op_count), 32'd0);

    // Full sweep at full rate
    do_reset();
    idx   = 0;
    got   = 0;
    cyc   = 0;
    stale = 0;
    exp_q.delete();
    while (got < 256 && cyc < 600) begin
      if (idx < 256) begin
        d0 = 5'(idx);
        bus.a = 4'(idx >> 4);
        bus.b = 4'(idx);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("sweep_unexpected", 32'(bus.diff), 32'hFFFF_FFFF);
        end else begin
          check("sweep", 32'(bus.diff), 32'(exp_q.pop_front()));
        end
        got++;
      end
      if (bus.in_valid) begin
        if (!bus.in_ready) stale++;
        else begin
          exp_q.push_back(ref_sub(bus.a, bus.b));
          idx++;
        end
      end
      step();
      cyc++;
    end
    check("sweep_got",      32'(got), 32'd256);
    check("sweep_stalls",   32'(stale), 32'd0);
    check("sweep_op_count", 32'(bus.op_count), 32'd256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
